// File: rtl/alu_reg_pkg.sv
// alu_reg shared definitions: sizes, register indices,
// ALU op codes, flag bit positions and opcode groups.
package alu_reg_pkg;

  localparam int DEF_DATASIZE = 8;
  localparam int DEF_ADDRSIZE = 3;
  localparam int DEF_INSTSIZE = 2;

  localparam int REG_B = 0;
  localparam int REG_C = 1;
  localparam int REG_D = 2;
  localparam int REG_E = 3;
  localparam int REG_H = 4;
  localparam int REG_L = 5;
  localparam int REG_F = 6;
  localparam int REG_M = 6;
  localparam int REG_A = 7;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_ADC = 3'b001,
    ALU_SUB = 3'b010,
    ALU_SBB = 3'b011,
    ALU_AND = 3'b100,
    ALU_XOR = 3'b101,
    ALU_OR  = 3'b110,
    ALU_CMP = 3'b111
  } alu_op_e;

  localparam int FLAG_CY  = 0;
  localparam int FLAG_ONE = 1;
  localparam int FLAG_P   = 2;
  localparam int FLAG_AC  = 4;
  localparam int FLAG_Z   = 6;
  localparam int FLAG_S   = 7;

  localparam logic [1:0] GRP_MOV = 2'b01;
  localparam logic [1:0] GRP_ALU = 2'b10;
  localparam logic [7:0] OP_HLT  = 8'h76;

  function automatic logic parity_even(input logic [7:0] v);
    return ~^v;
  endfunction

endpackage

// File: rtl/alu_reg_data_reg.sv
// Enabled register with asynchronous active-high clear.
// Used for I, T, the operand latch and each register file entry.
module data_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      data_out <= '0;
    else if (enb)
      data_out <= data_in;
  end

endmodule

// File: rtl/alu_reg.sv
// 8085-style datapath slice: I, T, operand latch,
// eight-entry register file and 8-bit ALU with flags.
module alu_reg
  import alu_reg_pkg::*;
#(
  parameter int DATASIZE = DEF_DATASIZE,
  parameter int ADDRSIZE = DEF_ADDRSIZE,
  parameter int INSTSIZE = DEF_INSTSIZE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enb_code,
  input  logic                enb_data,
  input  logic                enb_rreg,
  input  logic                enb_wreg,
  input  logic [DATASIZE-1:0] bus_data,
  output logic [INSTSIZE-1:0] chk_inst
);

  localparam int NREGS = 2 ** ADDRSIZE;

  logic [DATASIZE-1:0] inst;
  logic [DATASIZE-1:0] temp;
  logic [DATASIZE-1:0] opnd;
  logic [DATASIZE-1:0] rf [NREGS];

  logic [ADDRSIZE-1:0] sss;
  logic [ADDRSIZE-1:0] ddd;
  alu_op_e             alu_op;
  logic                is_mov;
  logic                is_alu;
  logic                is_hlt;
  logic                mov_wr;
  logic                alu_wr;

  assign sss    = inst[ADDRSIZE-1:0];
  assign ddd    = inst[2*ADDRSIZE-1:ADDRSIZE];
  assign alu_op = alu_op_e'(inst[5:3]);
  assign is_mov = inst[7:6] == GRP_MOV;
  assign is_alu = inst[7:6] == GRP_ALU;
  assign is_hlt = inst == OP_HLT;
  assign mov_wr = enb_wreg && is_mov && !is_hlt;
  assign alu_wr = enb_wreg && is_alu;

  assign chk_inst = {
    (inst[7:6] == 2'b00) && (inst[3:0] == 4'b1001),
    sss == ADDRSIZE'(REG_M)
  };

  // Code M selects T; index 6 as a source never reaches F.
  logic [DATASIZE-1:0] src;
  assign src = (sss == ADDRSIZE'(REG_M)) ? temp : rf[sss];

  logic [DATASIZE-1:0] acc;
  logic                cy_in;
  assign acc   = rf[REG_A];
  assign cy_in = rf[REG_F][FLAG_CY];

  logic [DATASIZE:0]   wide;
  logic [4:0]          nib;
  logic [DATASIZE-1:0] res;
  logic                cy;
  logic                ac;
  logic                cin;

  always_comb begin
    wide = '0;
    nib  = '0;
    res  = '0;
    cy   = 1'b0;
    ac   = 1'b0;
    cin  = 1'b0;
    unique case (alu_op)
      ALU_ADD, ALU_ADC: begin
        cin  = (alu_op == ALU_ADC) && cy_in;
        wide = {1'b0, acc} + {1'b0, opnd}
             + (DATASIZE+1)'(cin);
        nib  = {1'b0, acc[3:0]} + {1'b0, opnd[3:0]}
             + 5'(cin);
        res  = wide[DATASIZE-1:0];
        cy   = wide[DATASIZE];
        ac   = nib[4];
      end
      ALU_SUB, ALU_SBB, ALU_CMP: begin
        cin  = (alu_op == ALU_SBB) && cy_in;
        wide = {1'b0, acc} - {1'b0, opnd}
             - (DATASIZE+1)'(cin);
        nib  = {1'b0, acc[3:0]} - {1'b0, opnd[3:0]}
             - 5'(cin);
        res  = wide[DATASIZE-1:0];
        cy   = wide[DATASIZE];
        ac   = nib[4];
      end
      ALU_AND: begin
        res = acc & opnd;
        ac  = 1'b1;
      end
      ALU_XOR: res = acc ^ opnd;
      ALU_OR:  res = acc | opnd;
    endcase
  end

  logic [DATASIZE-1:0] f_new;

  always_comb begin
    f_new           = '0;
    f_new[FLAG_S]   = res[7];
    f_new[FLAG_Z]   = res == '0;
    f_new[FLAG_AC]  = ac;
    f_new[FLAG_P]   = parity_even(res[7:0]);
    f_new[FLAG_ONE] = 1'b1;
    f_new[FLAG_CY]  = cy;
  end

  logic [DATASIZE-1:0] dest_val;
  logic [NREGS-1:0]    rf_en;

  assign dest_val = is_alu ? res : opnd;

  always_comb begin
    rf_en = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (i == REG_F)
        rf_en[i] = alu_wr;
      else
        rf_en[i] = (mov_wr && ddd == ADDRSIZE'(i))
                || (alu_wr && i == REG_A
                    && alu_op != ALU_CMP);
    end
  end

  logic                temp_en;
  logic [DATASIZE-1:0] temp_d;

  assign temp_en = enb_data
                || (mov_wr && ddd == ADDRSIZE'(REG_M));
  assign temp_d  = enb_data ? bus_data : opnd;

  data_reg #(.WIDTH(DATASIZE)) inst_reg (
    .clk      (clk),
    .rst      (rst),
    .enb      (enb_code),
    .data_in  (bus_data),
    .data_out (inst)
  );

  data_reg #(.WIDTH(DATASIZE)) temp_reg (
    .clk      (clk),
    .rst      (rst),
    .enb      (temp_en),
    .data_in  (temp_d),
    .data_out (temp)
  );

  data_reg #(.WIDTH(DATASIZE)) opnd_reg (
    .clk      (clk),
    .rst      (rst),
    .enb      (enb_rreg),
    .data_in  (src),
    .data_out (opnd)
  );

  for (genvar i = 0; i < NREGS; i++) begin : reg_block
    data_reg #(.WIDTH(DATASIZE)) regs (
      .clk      (clk),
      .rst      (rst),
      .enb      (rf_en[i]),
      .data_in  ((i == REG_F) ? f_new : dest_val),
      .data_out (rf[i])
    );
  end

endmodule

// File: tb/tb_alu_reg.sv
// Directed vector bench for alu_reg: instruction table
// plus hand sequences for reset, latch ordering and abort.
module tb_alu_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enb_code = 1'b0;
  logic       enb_data = 1'b0;
  logic       enb_rreg = 1'b0;
  logic       enb_wreg = 1'b0;
  logic [7:0] bus_data = '0;
  logic [1:0] chk_inst;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_reg dut (
    .clk      (clk),
    .rst      (rst),
    .enb_code (enb_code),
    .enb_data (enb_data),
    .enb_rreg (enb_rreg),
    .enb_wreg (enb_wreg),
    .bus_data (bus_data),
    .chk_inst (chk_inst)
  );

  typedef struct {
    logic [7:0] code;
    bit         has_data;
    logic [7:0] data;
    int         idx;
    logic [7:0] exp_val;
    logic [7:0] exp_f;
    logic [1:0] exp_chk;
  } vec_t;

  localparam int NV = 21;
  vec_t vt [NV];

  // 0-7 register file, 8 T, 9 I, 10 operand latch
  function automatic logic [7:0] probe(input int idx);
    case (idx)
      0:  probe = dut.reg_block[0].regs.data_out;
      1:  probe = dut.reg_block[1].regs.data_out;
      2:  probe = dut.reg_block[2].regs.data_out;
      3:  probe = dut.reg_block[3].regs.data_out;
      4:  probe = dut.reg_block[4].regs.data_out;
      5:  probe = dut.reg_block[5].regs.data_out;
      6:  probe = dut.reg_block[6].regs.data_out;
      7:  probe = dut.reg_block[7].regs.data_out;
      8:  probe = dut.temp_reg.data_out;
      9:  probe = dut.inst_reg.data_out;
      10: probe = dut.opnd_reg.data_out;
      default: probe = 'x;
    endcase
  endfunction

  task automatic check(input string name,
                       input logic [7:0] got,
                       input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic pulse(input bit c, input bit d,
                       input bit r, input bit w,
                       input logic [7:0] bus);
    @(negedge clk);
    enb_code = c;
    enb_data = d;
    enb_rreg = r;
    enb_wreg = w;
    bus_data = bus;
    @(posedge clk);
    #1;
    enb_code = 1'b0;
    enb_data = 1'b0;
    enb_rreg = 1'b0;
    enb_wreg = 1'b0;
  endtask

  task automatic run_instr(input logic [7:0] code,
                           input bit has_data,
                           input logic [7:0] data);
    pulse(1, 0, 0, 0, code);
    if (has_data) pulse(0, 1, 0, 0, data);
    pulse(0, 0, 1, 0, 8'h00);
    pulse(0, 0, 1, 1, 8'h00);
  endtask

  initial begin
    vt[0]  = '{8'h7E, 1, 8'hAA, 7, 8'hAA, 8'h00, 2'b01};
    vt[1]  = '{8'h47, 0, 8'h00, 0, 8'hAA, 8'h00, 2'b00};
    vt[2]  = '{8'hAF, 0, 8'h00, 7, 8'h00, 8'h46, 2'b00};
    vt[3]  = '{8'h4F, 0, 8'h00, 1, 8'h00, 8'h46, 2'b00};
    vt[4]  = '{8'h7E, 1, 8'hF0, 7, 8'hF0, 8'h46, 2'b01};
    vt[5]  = '{8'h86, 1, 8'h20, 7, 8'h10, 8'h03, 2'b01};
    vt[6]  = '{8'h8E, 0, 8'h00, 7, 8'h31, 8'h02, 2'b01};
    vt[7]  = '{8'h46, 1, 8'h06, 0, 8'h06, 8'h02, 2'b01};
    vt[8]  = '{8'h7E, 1, 8'h05, 7, 8'h05, 8'h02, 2'b01};
    vt[9]  = '{8'hB8, 0, 8'h00, 7, 8'h05, 8'h97, 2'b00};
    vt[10] = '{8'hA0, 0, 8'h00, 7, 8'h04, 8'h12, 2'b00};
    vt[11] = '{8'h90, 0, 8'h00, 7, 8'hFE, 8'h93, 2'b00};
    vt[12] = '{8'h98, 0, 8'h00, 7, 8'hF7, 8'h82, 2'b00};
    vt[13] = '{8'h7E, 1, 8'h81, 7, 8'h81, 8'h82, 2'b01};
    vt[14] = '{8'hB0, 0, 8'h00, 7, 8'h87, 8'h86, 2'b00};
    vt[15] = '{8'h7E, 1, 8'h0F, 7, 8'h0F, 8'h86, 2'b01};
    vt[16] = '{8'h80, 0, 8'h00, 7, 8'h15, 8'h12, 2'b00};
    vt[17] = '{8'h70, 0, 8'h00, 8, 8'h06, 8'h12, 2'b00};
    vt[18] = '{8'hA8, 0, 8'h00, 7, 8'h13, 8'h02, 2'b00};
    vt[19] = '{8'h09, 0, 8'h00, 7, 8'h13, 8'h02, 2'b10};
    vt[20] = '{8'h76, 0, 8'h00, 8, 8'h06, 8'h02, 2'b01};

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i <= 10; i++)
      check($sformatf("reset_r%0d", i), probe(i), 8'h00);
    check("reset_chk", {6'b0, chk_inst}, 8'h00);

    for (int v = 0; v < NV; v++) begin
      run_instr(vt[v].code, vt[v].has_data, vt[v].data);
      check($sformatf("v%0d_val", v),
            probe(vt[v].idx), vt[v].exp_val);
      check($sformatf("v%0d_flags", v),
            probe(6), vt[v].exp_f);
      check($sformatf("v%0d_inst", v),
            probe(9), vt[v].code);
      check($sformatf("v%0d_chk", v),
            {6'b0, chk_inst}, {6'b0, vt[v].exp_chk});
    end

    // code and data on the same edge both load
    pulse(1, 1, 0, 0, 8'h4E);
    check("both_inst", probe(9), 8'h4E);
    check("both_temp", probe(8), 8'h4E);

    // write on a rreg+wreg edge uses the older latch
    run_instr(8'h46, 1, 8'h11);
    run_instr(8'h4E, 1, 8'h22);
    check("setup_b", probe(0), 8'h11);
    check("setup_c", probe(1), 8'h22);
    pulse(1, 0, 0, 0, 8'h40);
    pulse(0, 0, 1, 0, 8'h00);
    pulse(1, 0, 0, 0, 8'h41);
    pulse(0, 0, 1, 1, 8'h00);
    check("old_latch_b", probe(0), 8'h11);
    check("new_latch", probe(10), 8'h22);

    // reset mid-sequence aborts the pending MVI A
    pulse(1, 0, 0, 0, 8'h7E);
    pulse(0, 1, 0, 0, 8'h55);
    pulse(0, 0, 1, 0, 8'h00);
    check("pre_abort_latch", probe(10), 8'h55);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_inst_async", probe(9), 8'h00);
    check("abort_chk", {6'b0, chk_inst}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    pulse(0, 0, 1, 1, 8'h00);
    check("abort_a", probe(7), 8'h00);
    check("abort_t", probe(8), 8'h00);
    check("abort_b", probe(0), 8'h00);
    check("abort_f", probe(6), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
